// File: rtl/mont_exp_ctrl_if.sv
// mont_exp_ctrl_if: host request/result and montgomery core handshake bundle
interface mont_exp_ctrl_if #(parameter int N = 512, parameter int LW = 10);
  logic start;
  logic [N-1:0] in_x;
  logic [N-1:0] in_e;
  logic [LW-1:0] in_e_len;
  logic [N-1:0] in_m;
  logic [N-1:0] in_r;
  logic [N-1:0] in_r2;
  logic mont_start;
  logic [N-1:0] mont_a;
  logic [N-1:0] mont_b;
  logic [N-1:0] mont_m;
  logic [N-1:0] mont_result;
  logic mont_done;
  logic [N-1:0] result;
  logic done;
  logic busy;
  modport master (
    output start, in_x, in_e, in_e_len, in_m, in_r, in_r2, mont_result, mont_done,
    input mont_start, mont_a, mont_b, mont_m, result, done, busy
  );
  modport slave (
    input start, in_x, in_e, in_e_len, in_m, in_r, in_r2, mont_result, mont_done,
    output mont_start, mont_a, mont_b, mont_m, result, done, busy
  );
endinterface

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply X^E mod M over an external montgomery core
module mont_exp_ctrl #(
  parameter int N = 512,
  parameter int LW = 10
) (
  input logic clk,
  input logic resetn,
  mont_exp_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CONV_X, SQR, MUL, CONV_OUT, DONE} state_t;
  state_t st, nst;
  logic wt;
  logic [N-1:0] x_q, m_q, r2_q, acc, xt, e_sh, a_q, b_q, res_q;
  logic [N-1:0] na, nx, ne, na_op, nb_op;
  logic [LW-1:0] cnt, nc, el;
  logic ms, dn, bz;
  assign el = ({1'b0, bus.in_e_len} > (LW+1)'(N)) ? LW'(N) : bus.in_e_len;
  assign bus.mont_start = ms;
  assign bus.mont_a = a_q;
  assign bus.mont_b = b_q;
  assign bus.mont_m = m_q;
  assign bus.result = res_q;
  assign bus.done = dn;
  assign bus.busy = bz;
  // register updates and operands of the next op when the current core op completes
  always_comb begin
    na = acc;
    nx = xt;
    ne = e_sh;
    nc = cnt;
    nst = st;
    if (st == CONV_X) begin
      nx = bus.mont_result;
      nst = (cnt != '0) ? SQR : CONV_OUT;
    end else if (st == SQR || st == MUL) begin
      na = bus.mont_result;
      if (st == SQR && e_sh[N-1]) nst = MUL;
      else begin
        ne = e_sh << 1;
        nc = (cnt != '0) ? cnt - 1'b1 : cnt;
        nst = (nc == '0) ? CONV_OUT : SQR;
      end
    end else if (st == CONV_OUT) nst = DONE;
    na_op = (nst == SQR || nst == MUL || nst == CONV_OUT) ? na : x_q;
    nb_op = (nst == SQR) ? na : (nst == MUL) ? nx : N'(1);
  end
  // sequencer: ISSUE (wt=0, mont_start high) then WAIT (wt=1) until mont_done
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st <= IDLE;
      wt <= 1'b0;
      x_q <= '0;
      m_q <= '0;
      r2_q <= '0;
      acc <= '0;
      xt <= '0;
      e_sh <= '0;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      ms <= 1'b0;
      dn <= 1'b0;
      bz <= 1'b0;
    end else begin
      ms <= 1'b0;
      dn <= 1'b0;
      case (st)
        IDLE: if (bus.start) begin
          x_q <= bus.in_x;
          m_q <= bus.in_m;
          r2_q <= bus.in_r2;
          acc <= bus.in_r;
          cnt <= el;
          e_sh <= bus.in_e << (N - int'(el));
          st <= CONV_X;
          wt <= 1'b0;
          ms <= 1'b1;
          a_q <= bus.in_x;
          b_q <= bus.in_r2;
          bz <= 1'b1;
        end
        DONE: st <= IDLE;
        default: if (!wt) wt <= 1'b1;
        else if (bus.mont_done) begin
          acc <= na;
          xt <= nx;
          e_sh <= ne;
          cnt <= nc;
          st <= nst;
          wt <= 1'b0;
          if (st == CONV_OUT) begin
            res_q <= bus.mont_result;
            dn <= 1'b1;
            bz <= 1'b0;
          end else begin
            ms <= 1'b1;
            a_q <= na_op;
            b_q <= nb_op;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb_mont_exp_ctrl: table-driven and scoreboarded bench with a behavioural montgomery core
module tb_mont_exp_ctrl;
  localparam int N = 512;
  localparam int LW = 10;
  typedef struct {int m; int x; int e; int el; int res; int ops;} vec_t;
  typedef struct {logic [N-1:0] res; int ops;} exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  int ops = 0;
  int unstable = 0;
  int lat = 0;
  logic core_busy = 1'b0;
  logic core_done = 1'b0;
  logic inj_done = 1'b0;
  logic [N-1:0] core_res = '0;
  logic [N-1:0] cap_a = '0;
  logic [N-1:0] cap_b = '0;
  logic [N-1:0] op_a[$];
  logic [N-1:0] op_b[$];
  exp_t sb[$];
  vec_t vt[10];
  mont_exp_ctrl_if #(.N(N), .LW(LW)) bus();
  mont_exp_ctrl #(.N(N), .LW(LW)) dut(.clk(clk), .resetn(resetn), .bus(bus));
  assign bus.mont_done = core_done | inj_done;
  assign bus.mont_result = core_res;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m);
    logic [N+1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    p = p % {{N{1'b0}}, m};
    return p[N-1:0];
  endfunction

  function automatic logic [N-1:0] rmod(input logic [N-1:0] m);
    logic [N:0] big;
    big = (N+1)'(1) << N;
    big = big % {1'b0, m};
    return big[N-1:0];
  endfunction

  function automatic logic [N-1:0] gexp(input logic [N-1:0] x, input logic [N-1:0] e, input int el, input logic [N-1:0] m);
    logic [N-1:0] r;
    r = N'(1);
    for (int i = el - 1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, x, m);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rnd512();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // behavioural montgomery core with random 3..20 cycle latency, logs operands and checks they stay stable
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (bus.mont_start) begin
      ops <= ops + 1;
      op_a.push_back(bus.mont_a);
      op_b.push_back(bus.mont_b);
      cap_a <= bus.mont_a;
      cap_b <= bus.mont_b;
      core_res <= mont(bus.mont_a, bus.mont_b, bus.mont_m);
      lat <= $urandom_range(20, 3);
      core_busy <= 1'b1;
    end else if (core_busy) begin
      if (bus.mont_a !== cap_a || bus.mont_b !== cap_b) unstable <= unstable + 1;
      if (lat == 1) begin
        core_done <= 1'b1;
        core_busy <= 1'b0;
      end
      lat <= lat - 1;
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic run(input logic [N-1:0] m, input logic [N-1:0] x, input logic [N-1:0] e,
                     input logic [LW-1:0] el, input logic [N-1:0] res, input int nops,
                     input bit glitch, input string nm);
    int base, ub, cyc, ng;
    bit bz_bad;
    exp_t ex;
    logic [N-1:0] rm;
    rm = rmod(m);
    @(negedge clk);
    bus.in_m = m;
    bus.in_x = x;
    bus.in_e = e;
    bus.in_e_len = el;
    bus.in_r = rm;
    bus.in_r2 = mulmod(rm, rm, m);
    bus.start = 1'b1;
    sb.push_back('{res, nops});
    base = ops;
    ub = unstable;
    @(negedge clk);
    bus.start = 1'b0;
    if (glitch) begin
      bus.in_x = '1;
      bus.in_m = N'(7);
      bus.in_e = '0;
      bus.in_e_len = '0;
    end
    cyc = 0;
    ng = 0;
    bz_bad = 1'b0;
    while (!bus.done && cyc < 30000) begin
      if (!bus.busy) bz_bad = 1'b1;
      bus.start = glitch && ng < 5 && (cyc % 7) == 3;
      if (bus.start) ng++;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk({nm, " timeout"}, N'(cyc >= 30000), N'(0));
    chk({nm, " busy_during"}, N'(bz_bad), N'(0));
    chk({nm, " busy_at_done"}, N'(bus.busy), N'(0));
    chk({nm, " sb_nonempty"}, N'(sb.size() > 0), N'(1));
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      chk({nm, " result"}, bus.result, ex.res);
      chk({nm, " ops"}, N'(ops - base), N'(ex.ops));
    end
    chk({nm, " operand_stable"}, N'(unstable - ub), N'(0));
    @(negedge clk);
    chk({nm, " done_one_cycle"}, N'(bus.done), N'(0));
  endtask

  initial begin
    int ob, n, base;
    logic [N-1:0] r, m, x, e;
    bus.start = 1'b0;
    bus.in_x = '0;
    bus.in_e = '0;
    bus.in_e_len = '0;
    bus.in_m = '0;
    bus.in_r = '0;
    bus.in_r2 = '0;
    vt = '{'{13, 2, 5, 3, 6, 7}, '{13, 7, 0, 0, 1, 2}, '{13, 7, 1, 1, 7, 4},
           '{13, 3, 10, 4, 3, 8}, '{13, 5, 6, 3, 12, 7}, '{13, 2, 5, 5, 6, 9},
           '{13, 9, 0, 4, 1, 6}, '{11, 3, 4, 3, 4, 6}, '{13, 2, 13, 3, 6, 7},
           '{13, 2, 5, 600, 6, 516}};
    repeat (3) @(negedge clk);
    chk("rst mont_start", N'(bus.mont_start), N'(0));
    chk("rst mont_a", bus.mont_a, '0);
    chk("rst mont_b", bus.mont_b, '0);
    chk("rst mont_m", bus.mont_m, '0);
    chk("rst result", bus.result, '0);
    chk("rst done", N'(bus.done), N'(0));
    chk("rst busy", N'(bus.busy), N'(0));
    resetn = 1'b1;
    for (int i = 0; i < 10; i++)
      run(N'(vt[i].m), N'(vt[i].x), N'(vt[i].e), LW'(vt[i].el), N'(vt[i].res), vt[i].ops, 1'b0, $sformatf("vec%0d", i));
    // operand order for E=1, e_len=1
    r = rmod(N'(13));
    ob = op_a.size();
    run(N'(13), N'(7), N'(1), LW'(1), N'(7), 4, 1'b0, "e1");
    chk("e1 logged", N'(op_a.size() - ob), N'(4));
    if (op_a.size() >= ob + 4) begin
      chk("e1 op0 a", op_a[ob], N'(7));
      chk("e1 op0 b", op_b[ob], mulmod(r, r, N'(13)));
      chk("e1 op1 a", op_a[ob+1], r);
      chk("e1 op1 b", op_b[ob+1], r);
      chk("e1 op2 a", op_a[ob+2], r);
      chk("e1 op2 b", op_b[ob+2], mulmod(N'(7), r, N'(13)));
      chk("e1 op3 a", op_a[ob+3], mulmod(N'(7), r, N'(13)));
      chk("e1 op3 b", op_b[ob+3], N'(1));
    end
    // spurious mont_done in IDLE, then starts while busy
    base = ops;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("spurious busy", N'(bus.busy), N'(0));
    chk("spurious ops", N'(ops - base), N'(0));
    chk("spurious done", N'(bus.done), N'(0));
    run(N'(13), N'(2), N'(5), LW'(3), N'(6), 7, 1'b1, "glitch");
    // full-width random exponentiation
    m = rnd512() | {1'b1, {(N-2){1'b0}}, 1'b1};
    x = rnd512() % m;
    e = '1;
    run(m, x, e, LW'(512), gexp(x, e, 512, m), 1026, 1'b0, "big");
    // reset during the first MUL wait
    @(negedge clk);
    bus.in_m = N'(13);
    bus.in_x = N'(2);
    bus.in_e = N'(5);
    bus.in_e_len = LW'(3);
    bus.in_r = r;
    bus.in_r2 = mulmod(r, r, N'(13));
    bus.start = 1'b1;
    base = ops;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (ops - base < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst reach_mul", N'(ops - base), N'(3));
    resetn = 1'b0;
    #1;
    chk("midrst mont_start", N'(bus.mont_start), N'(0));
    chk("midrst mont_a", bus.mont_a, '0);
    chk("midrst mont_b", bus.mont_b, '0);
    chk("midrst mont_m", bus.mont_m, '0);
    chk("midrst result", bus.result, '0);
    chk("midrst done", N'(bus.done), N'(0));
    chk("midrst busy", N'(bus.busy), N'(0));
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    while (core_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("stale busy", N'(bus.busy), N'(0));
    chk("stale done", N'(bus.done), N'(0));
    chk("stale ops", N'(ops - base), N'(3));
    chk("stale result", bus.result, '0);
    run(N'(13), N'(2), N'(5), LW'(3), N'(6), 7, 1'b0, "after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
- Sequencer that computes X^E mod M using left-to-right square-and-multiply.
- Drives one external montgomery multiplier core through its start/done handshake.
- Sits between the host/bus interface and the montgomery core.
- Handles Montgomery-domain conversion in and out, so the host supplies plain X, E, M and R^2 mod M, and receives plain X^E mod M.

Parameters:
- N, 512, operand width in bits (core width; R = 2^N).
- LW, 10, width of the exponent-length field and the bit counter.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- in_x  in  N  base X, plain form, X < M
- in_e  in  N  exponent E
- in_e_len  in  LW  number of exponent bits to process (bits e_len-1..0)
- in_m  in  N  odd modulus M
- in_r  in  N  R mod M (Montgomery one)
- in_r2  in  N  R^2 mod M
- mont_start  out  1  start pulse to the core
- mont_a  out  N  core operand A
- mont_b  out  N  core operand B
- mont_m  out  N  core modulus
- mont_result  in  N  core result
- mont_done  in  1  core one-cycle completion pulse
- result  out  N  X^E mod M
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after an accepted start until done

Behaviour:
- Reset (async): all registers 0, state IDLE. result=0, done=0, busy=0, mont_start=0, mont_a/b/m=0. Reset mid-operation abandons the operation; any later mont_done is ignored in IDLE.
- Start acceptance in IDLE with start=1 latches X, E, M, R, R^2 and e_len. If e_len > N, clamp to N.
- Registers: acc (N), xt (N), e_sh (N, exponent left-aligned so the MSB under test is e_sh[N-1]), cnt (LW), op state.
- Every core operation is two phases:
  - ISSUE: one cycle, mont_start=1, operands valid.
  - WAIT: mont_start=0, operands held stable until the cycle mont_done=1.
  - mont_result is captured on the mont_done cycle. mont_m = latched M throughout.
- States and transitions:
  - IDLE: start -> CONV_X (acc := R, cnt := e_len, e_sh := E << (N - e_len)).
  - CONV_X: op(X, R^2) -> xt. Then SQR if cnt != 0, else CONV_OUT.
  - SQR: op(acc, acc) -> acc. If e_sh[N-1] -> MUL, else step.
  - MUL: op(acc, xt) -> acc, then step.
  - step: e_sh <<= 1, cnt -= 1. If the new cnt == 0 -> CONV_OUT, else SQR.
  - CONV_OUT: op(acc, 1) -> result register, then DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE and IDLE.
- Operation count = 2 + e_len + popcount(E[e_len-1:0]). Controller overhead is 1 cycle per op plus 1 cycle for DONE.
- result holds its value until the next CONV_OUT completes. It is not cleared by a new start.
- start while busy: ignored, with no side effects.
- mont_done outside WAIT: ignored.
- e_len = 0: loop skipped, result = R·R^-1 = 1 mod M (1 for M > 1). Exactly 2 core operations.
- E = 0 with e_len > 0: squarings only, result = 1.
- cnt never wraps. It is decremented only when nonzero.

Test Plan:
- M=13, X=2, E=5, e_len=3, behavioural montgomery core with random 3-20 cycle latency -> exactly 7 mont_start pulses, result=6, one done pulse, busy high throughout.
- M=13, X=7, E=0, e_len=0 -> 2 mont_start pulses, result=1, done pulses once.
- M=13, X=7, E=1, e_len=1 -> 4 mont_start pulses in order (X,R^2), (R,R), (acc,xt), (acc,1); result=7.
- Random 512-bit odd M, random X<M, E=2^512-1, e_len=512 -> 1026 ops, result matches golden modexp.
- Assert start 5 times during busy, plus a spurious mont_done in IDLE -> ignored; result and op count unchanged from the no-glitch run.
- Drop resetn during a MUL WAIT, release, then start a new exponentiation (M=13, X=2, E=5, e_len=3) -> all outputs 0 during reset, the stale mont_done is ignored, new result=6.
